// File: rtl/stage_memory.sv
// Memory stage of the rv32i pipeline: issues one data-memory request per load/store
// and fills the MEM/WB register. Optional alignment trap: STAGE_MEM_MISALIGN_CHK_EN.
package rv32i_types;
    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        rv32i_word  pc;
        rv32i_word  u_imm;
        logic [3:0] regfilemux_sel;
        logic [2:0] funct3;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } stage_mem_state_e;
endpackage

module stage_memory
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  rv32i_word         alu_out,
    input  logic              br_en,
    input  rv32i_word         rs2_out,
    input  rv32i_control_word ctrl,
    output rv32i_word         dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [3:0]        dmem_mbe,
    output rv32i_word         dmem_wdata,
    input  rv32i_word         dmem_rdata,
    input  logic              dmem_resp,
    output logic              stall_out,
    output logic              wb_valid,
    output rv32i_word         wb_alu_out,
    output logic              wb_br_en,
    output rv32i_word         wb_mem_rdata,
    output rv32i_control_word wb_ctrl,
    output logic              wb_misalign,
    output stage_mem_state_e  o_dbg_state
);

    // Handshake: dmem_read/dmem_write stay asserted with address, mbe and wdata
    // frozen until the single-cycle dmem_resp pulse; stall_out keeps the EX/MEM
    // inputs stable for the whole request, so they are still valid on the resp edge.

    stage_mem_state_e r_state;
    stage_mem_state_e w_next_state;

    rv32i_word  r_addr;
    rv32i_word  r_wdata;
    logic [3:0] r_mbe;
    logic       r_read;
    logic       r_write;

    logic [1:0] w_off;
    logic       w_memop_raw;
    logic       w_misalign;
    logic       w_memop;
    logic [3:0] w_st_mbe;
    rv32i_word  w_st_wdata;
    rv32i_word  w_rd_shift;
    logic [7:0] w_byte;
    logic [15:0] w_half;
    rv32i_word  w_ld_data;

    assign w_off       = alu_out[1:0];
    assign w_memop_raw = valid_in & (ctrl.mem_read | ctrl.mem_write);

`ifdef STAGE_MEM_MISALIGN_CHK_EN
    assign w_misalign = w_memop_raw &
                        (((ctrl.funct3[1:0] == 2'b01) & w_off[0]) |
                         ((ctrl.funct3[1:0] == 2'b10) & (w_off != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    // Misaligned accesses never reach memory; they retire like ALU ops.
    assign w_memop = w_memop_raw & ~w_misalign;

    always_comb begin
        w_next_state = r_state;
        stall_out    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    w_next_state = ST_BUSY;
                    stall_out    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (dmem_resp) begin
                    w_next_state = ST_IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_st_mbe   = 4'b1111;
        w_st_wdata = rs2_out;
        if (ctrl.mem_write && !ctrl.mem_read) begin
            case (ctrl.funct3[1:0])
                2'b00: begin
                    w_st_mbe   = 4'b0001 << w_off;
                    w_st_wdata = rs2_out << {w_off, 3'b000};
                end
                2'b01: begin
                    w_st_mbe   = w_off[1] ? 4'b1100 : 4'b0011;
                    w_st_wdata = w_off[1] ? {rs2_out[15:0], 16'h0000} : rs2_out;
                end
                default: begin
                    w_st_mbe   = 4'b1111;
                    w_st_wdata = rs2_out;
                end
            endcase
        end
    end

    assign w_rd_shift = dmem_rdata >> {w_off, 3'b000};
    assign w_byte     = w_rd_shift[7:0];
    assign w_half     = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_ld_data = dmem_rdata;
        case (ctrl.funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h000000, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0000, w_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mbe   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE) begin
                if (w_memop) begin
                    r_addr  <= {alu_out[31:2], 2'b00};
                    r_mbe   <= w_st_mbe;
                    r_wdata <= w_st_wdata;
                    r_read  <= ctrl.mem_read;
                    r_write <= ~ctrl.mem_read & ctrl.mem_write;
                end
            end else if (dmem_resp) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_mbe   <= '0;
            end
        end
    end

    // MEM/WB register; only the valid bit moves on bubbles and stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            wb_alu_out   <= '0;
            wb_br_en     <= 1'b0;
            wb_mem_rdata <= '0;
            wb_ctrl      <= '0;
            wb_misalign  <= 1'b0;
        end else if (stall_out || !valid_in) begin
            wb_valid <= 1'b0;
        end else begin
            wb_valid     <= 1'b1;
            wb_alu_out   <= alu_out;
            wb_br_en     <= br_en;
            wb_ctrl      <= ctrl;
            wb_misalign  <= w_misalign;
            wb_mem_rdata <= ((r_state == ST_BUSY) && ctrl.mem_read) ? w_ld_data : '0;
        end
    end

    assign dmem_address = r_addr;
    assign dmem_read    = r_read;
    assign dmem_write   = r_write;
    assign dmem_mbe     = r_mbe;
    assign dmem_wdata   = r_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameters: none; all widths fixed by rv32i_types (rv32i_word = 32 bits, rv32i_control_word).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 valid_in  in  1  EX/MEM register holds a live instruction.
REQ-005 alu_out  in  32  ALU result / effective address.
REQ-006 br_en  in  1  compare result from execute.
REQ-007 rs2_out  in  32  store data.
REQ-008 ctrl  in  rv32i_control_word  uses mem_read, mem_write, funct3, regfilemux_sel, u_imm, pc.
REQ-009 dmem_address  out  32  word-aligned address, {alu_out[31:2],2'b00}.
REQ-010 dmem_read / dmem_write  out  1 each  registered request strobes.
REQ-011 dmem_mbe  out  4  byte enables; dmem_wdata  out  32  lane-aligned store data.
REQ-012 dmem_rdata  in  32; dmem_resp  in  1  one-cycle completion pulse.
REQ-013 stall_out  out  1  freeze upstream stages and hold this block's inputs.
REQ-014 wb_valid, wb_alu_out, wb_br_en, wb_mem_rdata, wb_ctrl  out  1/32/1/32/ctrl  MEM/WB register feeding writeback.
REQ-015 wb_misalign  out  1  misaligned-access flag for the writeback instruction.

Function
REQ-016 The block SHALL have FSM states IDLE and BUSY.
REQ-017 memop = valid_in & (ctrl.mem_read | ctrl.mem_write).
REQ-018 IDLE & memop: at the clock edge, go to BUSY, latch address/mbe/wdata, set dmem_read or dmem_write.
REQ-019 BUSY: strobes, address, mbe, wdata held constant until dmem_resp=1; on that edge return to IDLE, clear strobes.
REQ-020 stall_out = (IDLE & memop) | (BUSY & ~dmem_resp), combinational; upstream inputs stable while 1.
REQ-021 Non-memory valid instruction: 1-cycle latency into MEM/WB, no stall; memory op: loaded into MEM/WB on the dmem_resp edge.
REQ-022 valid_in=0 with stall_out=0: wb_valid<=0 (bubble); other wb_* hold.
REQ-023 While stall_out=1: wb_valid<=0; MEM/WB is not loaded with the stalled instruction.
REQ-024 Loads, off=alu_out[1:0]: lb/lbu select byte off and sign/zero-extend; lh/lhu select half off[1] and extend; lw passes the word.
REQ-025 Stores: sb mbe=4'b0001<<off, wdata=rs2<<(8*off); sh mbe=4'b0011<<(2*off[1]), wdata=rs2<<(16*off[1]); sw mbe=4'b1111, wdata=rs2.
REQ-026 Loads drive dmem_mbe=4'b1111; idle strobes drive mbe=0.
REQ-027 dmem_resp in IDLE SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, dmem_read=dmem_write=0, mbe=0, wb_valid=0, all wb_* and wb_misalign=0, including mid-BUSY.
REQ-029 After rst deasserts, the first edge with memop SHALL start a fresh request; no aborted request is replayed.

Configuration
REQ-030 Macro STAGE_MEM_MISALIGN_CHK_EN.
REQ-031 Defined: lh/lhu/sh with off[0]=1, or lw/sw with off!=0, issue no memory request, incur no stall, pass through in 1 cycle with wb_misalign=1 and wb_mem_rdata=0.
REQ-032 Undefined: wb_misalign tied 0; lane selection uses only the offset bits named in REQ-024/025 (off[0] ignored for halfwords; off ignored for words).

Verification
REQ-033 lw, alu_out=0x100, dmem_resp 3 cycles after the request, rdata=0xDEADBEEF -> stall_out high 4 cycles, then wb_valid=1, wb_mem_rdata=0xDEADBEEF.
REQ-034 lb at 0x103, rdata=0x80xxxxxx -> 0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh at 0x102, rs2=0x1234ABCD -> mbe=4'b1100, wdata=0xABCD0000, dmem_write held until resp.
REQ-036 add (no memop) back-to-back x3 -> no stall, wb_valid=1 each cycle, wb_alu_out matches.
REQ-037 rst=0 two cycles into BUSY load -> strobes drop same cycle, wb_valid=0, state IDLE after release.
REQ-038 With STAGE_MEM_MISALIGN_CHK_EN, lw at 0x102 -> no dmem_read, wb_misalign=1 next cycle; without it -> read of 0x100 proceeds normally.
